// File: rtl/game_flow_controller_if.sv
// Signal bundle between the round sequencer and the buttons / score block.
// state_dbg exposes the internal sequencer state for external checkers.
interface game_flow_controller_if;
    logic       BTN_START;
    logic       BTN_MODE;
    logic       SCORE_WIN;
    logic       WIN;
    logic       LOST;
    logic [1:0] MSM_STATE;
    logic       TIMED_MODE;
    logic       SCORE_RESET;
    logic       ROUND_DONE;
    logic [2:0] state_dbg;

    modport master (
        input  BTN_START, BTN_MODE, SCORE_WIN, WIN, LOST,
        output MSM_STATE, TIMED_MODE, SCORE_RESET, ROUND_DONE, state_dbg
    );

    modport slave (
        output BTN_START, BTN_MODE, SCORE_WIN, WIN, LOST,
        input  MSM_STATE, TIMED_MODE, SCORE_RESET, ROUND_DONE, state_dbg
    );
endinterface

// File: rtl/game_flow_controller.sv
// Round sequencer for the snake game: debounces START/MODE, arms the score
// block, runs PLAY, shows WIN/LOSE for a fixed hold time, then returns to IDLE.
module game_flow_controller #(
    parameter int DEBOUNCE_MAX = 999999,
    parameter int ARM_CYCLES   = 4,
    parameter int HOLD_MAX     = 299999999,
    parameter int CNT_W        = 29
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    game_flow_controller_if.master bus
);
    localparam int DB_W = $clog2(DEBOUNCE_MAX + 1);

    typedef enum logic [2:0] {IDLE, ARM, PLAY, WIN_S, LOSE_S} state_t;

    // Bit 0 is START, bit 1 is MODE throughout the button path.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]            acc_q, acc_d, press_q, press_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

    state_t                state_q, state_d;
    logic                  timed_q, timed_d;
    logic [3:0]            arm_q, arm_d;
    logic [CNT_W-1:0]      hold_q, hold_d;
    logic [1:0]            msm_q, msm_d;
    logic                  score_reset_q, score_reset_d;
    logic                  round_done_q, round_done_d;
    logic                  abort;
    logic                  press_start, press_mode;

    assign btn_raw     = {bus.BTN_MODE, bus.BTN_START};
    assign press_start = press_q[0];
    assign press_mode  = press_q[1];

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        acc_d    = acc_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == acc_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_MAX)) begin
                acc_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
        press_d = acc_d & ~acc_q;
    end

    always_comb begin
        state_d = state_q;
        timed_d = timed_q;
        arm_d   = arm_q;
        hold_d  = hold_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_start) begin
                    state_d = ARM;
                    arm_d   = '0;
                end else if (press_mode) begin
                    timed_d = ~timed_q;
                end
            end
            ARM: begin
                if (arm_q == 4'(ARM_CYCLES - 1)) state_d = PLAY;
                else                             arm_d   = arm_q + 4'd1;
            end
            PLAY: begin
                hold_d = '0;
                if (press_start) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (timed_q) begin
                    if (bus.WIN)       state_d = WIN_S;
                    else if (bus.LOST) state_d = LOSE_S;
                end else if (bus.SCORE_WIN) begin
                    state_d = WIN_S;
                end
            end
            WIN_S, LOSE_S: begin
                // Replay takes precedence over the hold timeout.
                if (press_start) begin
                    state_d = ARM;
                    arm_d   = '0;
                    hold_d  = '0;
                end else if (hold_q == CNT_W'(HOLD_MAX)) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            PLAY:    msm_d = 2'd1;
            WIN_S:   msm_d = 2'd2;
            LOSE_S:  msm_d = 2'd3;
            default: msm_d = 2'd0;
        endcase
        score_reset_d = (state_d == ARM) || abort;
        round_done_d  = (state_q == PLAY) && (state_d == WIN_S || state_d == LOSE_S);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            acc_q         <= '0;
            press_q       <= '0;
            db_cnt_q      <= '0;
            state_q       <= IDLE;
            timed_q       <= 1'b0;
            arm_q         <= '0;
            hold_q        <= '0;
            msm_q         <= 2'd0;
            score_reset_q <= 1'b0;
            round_done_q  <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            acc_q         <= acc_d;
            press_q       <= press_d;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            timed_q       <= timed_d;
            arm_q         <= arm_d;
            hold_q        <= hold_d;
            msm_q         <= msm_d;
            score_reset_q <= score_reset_d;
            round_done_q  <= round_done_d;
        end
    end

    assign bus.MSM_STATE   = msm_q;
    assign bus.TIMED_MODE  = timed_q;
    assign bus.SCORE_RESET = score_reset_q;
    assign bus.ROUND_DONE  = round_done_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: stimulus pushes expected output
// changes (with required dwell of the previous value) into a queue; a monitor pops on every change.
module tb_game_flow_controller;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_flow_controller_if bus();

    game_flow_controller #(
        .DEBOUNCE_MAX(3),
        .ARM_CYCLES  (2),
        .HOLD_MAX    (9),
        .CNT_W       (4)
    ) dut (
        .CLK   (clk),
        .RESETN(rst_n),
        .bus   (bus)
    );

    // Entry layout: {dwell_of_previous_value[7:0], msm[1:0], timed, score_reset, round_done}
    // A dwell of 0 means the previous value's duration is not checked.
    logic [12:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [12:0] ev(input logic [1:0] m, input logic t,
                                       input logic sr, input logic rd,
                                       input logic [7:0] dw);
        return {dw, m, t, sr, rd};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        bus.BTN_START = 1'b1;
        tick(8);
        bus.BTN_START = 1'b0;
        tick(8);
    endtask

    task automatic press_mode();
        bus.BTN_MODE = 1'b1;
        tick(8);
        bus.BTN_MODE = 1'b0;
        tick(8);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: any change of the output vector consumes one expected entry.
    initial begin
        logic [4:0]  last;
        logic [4:0]  cur;
        logic [12:0] e;
        int          dwell;
        last  = '0;
        dwell = 0;
        forever begin
            @(negedge clk);
            cur = {bus.MSM_STATE, bus.TIMED_MODE, bus.SCORE_RESET, bus.ROUND_DONE};
            if (cur !== last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %b after %0d cycles, none expected", cur, dwell);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e[4:0]) begin
                        errors++;
                        $display("FAIL outputs: got %b expected %b", cur, e[4:0]);
                    end
                    if (e[12:5] != 8'd0) begin
                        checks++;
                        if (dwell != int'(e[12:5])) begin
                            errors++;
                            $display("FAIL dwell_of_%b: got %0d cycles expected %0d", last, dwell, e[12:5]);
                        end
                    end
                end
                last  = cur;
                dwell = 1;
            end else begin
                dwell++;
            end
        end
    end

    initial begin
        bus.BTN_START = 1'b0;
        bus.BTN_MODE  = 1'b0;
        bus.SCORE_WIN = 1'b0;
        bus.WIN       = 1'b0;
        bus.LOST      = 1'b0;
        tick(3);
        check("reset_msm_state", 8'(bus.MSM_STATE), 8'd0);
        check("reset_score_reset", 8'(bus.SCORE_RESET), 8'd0);
        rst_n = 1'b1;
        tick(2);

        // Short glitch on START: no event, no output change.
        bus.BTN_START = 1'b1;
        tick(3);
        bus.BTN_START = 1'b0;
        tick(10);
        check("glitch_state", 8'(bus.MSM_STATE), 8'd0);

        // Clean press: ARM for 2 cycles, then PLAY.
        exp_q.push_back(ev(2'd0, 1'b0, 1'b1, 1'b0, 8'd0));
        exp_q.push_back(ev(2'd1, 1'b0, 1'b0, 1'b0, 8'd2));
        press_start();
        tick(2);

        // Untimed: WIN/LOST ignored, SCORE_WIN wins, 10-cycle hold.
        bus.WIN  = 1'b1;
        bus.LOST = 1'b1;
        tick(2);
        bus.WIN  = 1'b0;
        bus.LOST = 1'b0;
        tick(3);
        exp_q.push_back(ev(2'd2, 1'b0, 1'b0, 1'b1, 8'd0));
        exp_q.push_back(ev(2'd2, 1'b0, 1'b0, 1'b0, 8'd1));
        exp_q.push_back(ev(2'd0, 1'b0, 1'b0, 1'b0, 8'd9));
        bus.SCORE_WIN = 1'b1;
        tick(1);
        bus.SCORE_WIN = 1'b0;
        tick(14);

        // Timed mode, WIN and LOST together: WIN has priority.
        exp_q.push_back(ev(2'd0, 1'b1, 1'b0, 1'b0, 8'd0));
        press_mode();
        exp_q.push_back(ev(2'd0, 1'b1, 1'b1, 1'b0, 8'd0));
        exp_q.push_back(ev(2'd1, 1'b1, 1'b0, 1'b0, 8'd2));
        press_start();
        exp_q.push_back(ev(2'd2, 1'b1, 1'b0, 1'b1, 8'd0));
        exp_q.push_back(ev(2'd2, 1'b1, 1'b0, 1'b0, 8'd1));
        exp_q.push_back(ev(2'd0, 1'b1, 1'b0, 1'b0, 8'd9));
        bus.WIN  = 1'b1;
        bus.LOST = 1'b1;
        tick(1);
        bus.WIN  = 1'b0;
        bus.LOST = 1'b0;
        tick(14);

        // Timed lose, replay with START seen at hold count 4.
        exp_q.push_back(ev(2'd0, 1'b1, 1'b1, 1'b0, 8'd0));
        exp_q.push_back(ev(2'd1, 1'b1, 1'b0, 1'b0, 8'd2));
        press_start();
        exp_q.push_back(ev(2'd3, 1'b1, 1'b0, 1'b1, 8'd0));
        exp_q.push_back(ev(2'd3, 1'b1, 1'b0, 1'b0, 8'd1));
        exp_q.push_back(ev(2'd0, 1'b1, 1'b1, 1'b0, 8'd4));
        exp_q.push_back(ev(2'd1, 1'b1, 1'b0, 1'b0, 8'd2));
        bus.BTN_START = 1'b1;
        tick(1);
        bus.LOST = 1'b1;
        tick(1);
        bus.LOST = 1'b0;
        tick(6);
        bus.BTN_START = 1'b0;
        tick(8);

        // MODE ignored in PLAY; START aborts with a one-cycle clear pulse.
        press_mode();
        check("mode_in_play", 8'(bus.TIMED_MODE), 8'd1);
        exp_q.push_back(ev(2'd0, 1'b1, 1'b1, 1'b0, 8'd0));
        exp_q.push_back(ev(2'd0, 1'b1, 1'b0, 1'b0, 8'd1));
        press_start();

        // Reach WIN_S, then drop RESETN between clock edges.
        exp_q.push_back(ev(2'd0, 1'b1, 1'b1, 1'b0, 8'd0));
        exp_q.push_back(ev(2'd1, 1'b1, 1'b0, 1'b0, 8'd2));
        exp_q.push_back(ev(2'd2, 1'b1, 1'b0, 1'b1, 8'd0));
        exp_q.push_back(ev(2'd2, 1'b1, 1'b0, 1'b0, 8'd1));
        press_start();
        bus.WIN = 1'b1;
        tick(1);
        bus.WIN = 1'b0;
        tick(3);
        check("pre_reset_msm", 8'(bus.MSM_STATE), 8'd2);
        #3;
        exp_q.push_back(ev(2'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        rst_n = 1'b0;
        #1;
        check("async_msm_state", 8'(bus.MSM_STATE), 8'd0);
        check("async_timed_mode", 8'(bus.TIMED_MODE), 8'd0);
        check("async_score_reset", 8'(bus.SCORE_RESET), 8'd0);
        check("async_round_done", 8'(bus.ROUND_DONE), 8'd0);
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("timed_after_reset", 8'(bus.TIMED_MODE), 8'd0);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        tick(3);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
